// File: rtl/sync_hs_ctl_pkg.sv
// sync_hs_ctl_pkg: shared state encodings and default sizes for the req/ack handshake controllers
package sync_hs_ctl_pkg;
    typedef enum logic [1:0] {
        SYNC_HS_IDLE  = 2'd0,
        SYNC_HS_REQ   = 2'd1,
        SYNC_HS_ACKLO = 2'd2
    } sync_hs_state_e;
    localparam int SYNC_HS_DW          = 32;
    localparam int SYNC_HS_SYNC_STAGES = 2;
    localparam int SYNC_HS_TO_W        = 10;
    localparam int SYNC_HS_TO_MAX      = 1000;
endpackage

// File: rtl/sync_hs_ctl_if.sv
// sync_hs_ctl_if: local requester and foreign-domain handshake signals of the sender controller
interface sync_hs_ctl_if import sync_hs_ctl_pkg::*; #(parameter int DW = SYNC_HS_DW);
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic          xreq_out;
    logic [DW-1:0] xdata_out;
    logic          xack_async;
    logic          done;
    logic          timeout_err;
    logic          busy;
    modport master (
        input  tx_valid, tx_data, xack_async,
        output tx_ready, xreq_out, xdata_out, done, timeout_err, busy
    );
    modport slave (
        output tx_valid, tx_data, xack_async,
        input  tx_ready, xreq_out, xdata_out, done, timeout_err, busy
    );
endinterface

// File: rtl/sync_hs_ctl_sync_ff_chain.sv
// sync_ff_chain: reset-to-0 flop chain synchronizing an asynchronous level into clk
module sync_ff_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic arst_l,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    // shift the input one stage deeper each edge
    always_comb chain_d = {chain_q[STAGES-2:0], d};
    // chain register, cleared asynchronously
    always_ff @(posedge clk or negedge arst_l)
        if (!arst_l) chain_q <= '0;
        else         chain_q <= chain_d;
    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/sync_hs_ctl.sv
// sync_hs_ctl: sender side of a four-phase req/ack crossing with bundled data and request timeout
module sync_hs_ctl import sync_hs_ctl_pkg::*; #(
    parameter int DW          = SYNC_HS_DW,
    parameter int SYNC_STAGES = SYNC_HS_SYNC_STAGES,
    parameter int TO_W        = SYNC_HS_TO_W,
    parameter int TO_MAX      = SYNC_HS_TO_MAX
) (
    input logic            rclk,
    input logic            arst_l,
    sync_hs_ctl_if.master  bus
);
    localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TO_MAX);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX - 1);
    localparam bit              TO_EN   = TO_MAX != 0;
    sync_hs_state_e  state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            xreq_q, xreq_d;
    logic [DW-1:0]   xdata_q, xdata_d;
    logic            done_q, done_d;
    logic            to_q, to_d;
    logic            ack_s;
    logic            accept;
    sync_ff_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (rclk),
        .arst_l (arst_l),
        .d      (bus.xack_async),
        .q      (ack_s)
    );
    assign bus.tx_ready = (state_q == SYNC_HS_IDLE) & ~ack_s;
    assign accept       = bus.tx_valid & bus.tx_ready;
    // next state; ack takes priority over the final timeout cycle, data only loads on accept
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xreq_d  = xreq_q;
        xdata_d = xdata_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            SYNC_HS_IDLE: if (accept) begin
                xdata_d = bus.tx_data;
                xreq_d  = 1'b1;
                cnt_d   = '0;
                state_d = SYNC_HS_REQ;
            end
            SYNC_HS_REQ: begin
                cnt_d = (cnt_q == TO_LIM) ? cnt_q : cnt_q + TO_W'(1);
                if (ack_s) begin
                    xreq_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = SYNC_HS_ACKLO;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    xreq_d  = 1'b0;
                    to_d    = 1'b1;
                    state_d = SYNC_HS_ACKLO;
                end
            end
            SYNC_HS_ACKLO: if (!ack_s) state_d = SYNC_HS_IDLE;
            default: state_d = SYNC_HS_IDLE;
        endcase
    end
    // state, counter, request, data and pulse registers
    always_ff @(posedge rclk or negedge arst_l)
        if (!arst_l) begin
            state_q <= SYNC_HS_IDLE;
            cnt_q   <= '0;
            xreq_q  <= 1'b0;
            xdata_q <= '0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xreq_q  <= xreq_d;
            xdata_q <= xdata_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    assign bus.xreq_out    = xreq_q;
    assign bus.xdata_out   = xdata_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = to_q;
    assign bus.busy        = state_q != SYNC_HS_IDLE;
endmodule

// File: tb/tb_sync_hs_ctl.sv
// tb_sync_hs_ctl: randomized responder with a timing-rule reference model for sync_hs_ctl
module tb_sync_hs_ctl;
    localparam int S  = 2;
    localparam int TM = 8;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic arst_l = 1'b0;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_done = 0;
    logic hist [0:16383];
    sync_hs_ctl_if #(.DW(DW)) bus();
    sync_hs_ctl #(.DW(DW), .SYNC_STAGES(S), .TO_W(10), .TO_MAX(TM)) dut (
        .rclk   (clk),
        .arst_l (arst_l),
        .bus    (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) hist[cyc % 16384] = bus.xack_async;
    always @(negedge clk) if (bus.done === 1'b1) n_done++;
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    function automatic logic acks(input int c);
        return (c >= S) ? hist[(c - S) % 16384] : 1'b0;
    endfunction
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0d: got %0h expected %0h", tag, cyc, act, exp);
    endtask
    task automatic xfer(input logic [DW-1:0] w, input int d, input int low, input bit nv, input logic [DW-1:0] nw);
        int k, e, f, n;
        bit aw, acklo, bsy;
        n = 0;
        while (bus.tx_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", bus.tx_ready, 1'b1);
        @(posedge clk);
        #1;
        k = cyc;
        bus.tx_valid = nv;
        bus.tx_data  = nv ? nw : DW'($urandom);
        aw = d + S + 1 <= TM;
        e  = aw ? k + d + S + 1 : k + TM;
        f  = ((e > k + d) ? e : k + d) + low;
        acklo = 1'b0;
        for (int c = k; c <= f + S + 1; c++) begin
            if (c > k) begin
                @(posedge clk);
                #1;
            end
            if (c == k + d) bus.xack_async = 1'b1;
            if (c == f) bus.xack_async = 1'b0;
            if (c == e) acklo = 1'b1;
            else if (c > e && acklo && !acks(c - 1)) acklo = 1'b0;
            @(negedge clk);
            bsy = (c < e) || acklo;
            chk("xreq", bus.xreq_out, c < e);
            chk("xdata", bus.xdata_out, w);
            chk("done", bus.done, aw && c == e);
            chk("timeout", bus.timeout_err, !aw && c == e);
            chk("busy", bus.busy, bsy);
            chk("tx_ready", bus.tx_ready, !bsy && !acks(c));
        end
    endtask
    task automatic one(input logic [DW-1:0] w, input int d, input int low);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        xfer(w, d, low, 1'b0, '0);
    endtask
    task automatic run_seq(input int n, input int dmax);
        logic [DW-1:0] cur, nxt;
        int d;
        bit nv;
        cur = DW'($urandom);
        bus.tx_data  = cur;
        bus.tx_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            d   = $urandom_range(0, dmax);
            nxt = DW'($urandom);
            nv  = (i < n - 1) && (d + S + 1 <= TM);
            xfer(cur, d, $urandom_range(1, 4), nv, nxt);
            if (!nv && i < n - 1) begin
                bus.tx_data  = nxt;
                bus.tx_valid = 1'b1;
            end
            cur = nxt;
        end
    endtask
    task automatic glitch();
        int c0;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.xack_async = 1'b1;
        for (int c = c0; c <= c0 + S + 2; c++) begin
            if (c > c0) begin
                @(posedge clk);
                #1;
                bus.xack_async = 1'b0;
            end
            @(negedge clk);
            chk("glitch_busy", bus.busy, 1'b0);
            chk("glitch_done", bus.done, 1'b0);
            chk("glitch_ready", bus.tx_ready, !acks(c));
        end
    endtask
    task automatic rst_mid(input bit al);
        bus.tx_data  = DW'($urandom) | 32'h1;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        if (al) bus.xack_async = 1'b1;
        repeat (al ? S + 3 : 3) @(posedge clk);
        #2;
        chk("pre_rst_busy", bus.busy, 1'b1);
        chk("pre_rst_xreq", bus.xreq_out, !al);
        arst_l = 1'b0;
        bus.xack_async = 1'b0;
        #1;
        chk("rst_xreq", bus.xreq_out, 1'b0);
        chk("rst_xdata", bus.xdata_out, '0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_timeout", bus.timeout_err, 1'b0);
        chk("rst_ready", bus.tx_ready, 1'b1);
        repeat (2) @(negedge clk);
        arst_l = 1'b1;
    endtask
    initial begin
        int d0;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = '0;
        bus.xack_async = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_xreq", bus.xreq_out, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        arst_l = 1'b1;
        #1;
        chk("init_xreq", bus.xreq_out, 1'b0);
        chk("init_xdata", bus.xdata_out, '0);
        chk("init_done", bus.done, 1'b0);
        chk("init_timeout", bus.timeout_err, 1'b0);
        chk("init_busy", bus.busy, 1'b0);
        chk("init_ready", bus.tx_ready, 1'b1);
        @(negedge clk);
        chk("init_ready_cyc1", bus.tx_ready, 1'b1);
        glitch();
        one(32'hDEADBEEF, 3, 2);
        one(DW'($urandom), 40, 2);
        one(DW'($urandom), TM - S - 1, 2);
        one(DW'($urandom), TM - S, 3);
        one(DW'($urandom), 12, 2);
        d0 = n_done;
        run_seq(4, TM - S - 1);
        chk("b2b_done_cnt", n_done - d0, 4);
        rst_mid(1'b0);
        one(DW'($urandom), 1, 1);
        rst_mid(1'b1);
        one(DW'($urandom), 0, 1);
        run_seq(30, 12);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
